// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle datapath: sequences fetch/decode/execute,
// drives every datapath select/enable, counts retired instructions, flags bad opcodes.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUIn1Sel,
    output logic [1:0]       ALUIn2Sel,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EX     = 4'd6,
        R_WB     = 4'd7,
        BEQ      = 4'd8,
        JMP      = 4'd9,
        I_EX     = 4'd10,
        I_WB     = 4'd11
    } state_t;

    // fetch marks the state whose IRWrite/PCWrite are qualified by mem_ready
    typedef struct packed {
        logic       fetch;
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       m2r;
        logic       rdst;
        logic       rw;
        logic       in1;
        logic [1:0] in2;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
    } ctl_t;

    function automatic ctl_t dec(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.fetch = 1'b1; c.mrd = 1'b1; c.in2 = 2'b01; end
            DECODE:   c.in2 = 2'b10;
            MEM_ADDR: begin c.in1 = 1'b1; c.in2 = 2'b10; end
            MEM_RD:   begin c.mrd = 1'b1; c.iord = 1'b1; end
            MEM_WB:   begin c.rw = 1'b1; c.m2r = 1'b1; end
            MEM_WR:   begin c.mwr = 1'b1; c.iord = 1'b1; end
            R_EX:     begin c.in1 = 1'b1; c.aluop = 2'b10; end
            R_WB:     begin c.rw = 1'b1; c.rdst = 1'b1; end
            BEQ:      begin c.in1 = 1'b1; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcsrc = 2'b01; end
            JMP:      begin c.pcw = 1'b1; c.pcsrc = 2'b10; end
            I_EX:     begin c.in1 = 1'b1; c.in2 = 2'b10; end
            I_WB:     c.rw = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t cur, nxt;
    ctl_t   ctl;
    logic   retire, bad_op;

    // zero only qualifies PCWriteCond inside the datapath
    logic unused_zero;
    assign unused_zero = zero;

    always_comb begin
        nxt    = cur;
        retire = 1'b0;
        bad_op = 1'b0;
        case (cur)
            FETCH:    if (mem_ready) nxt = DECODE;
            DECODE: begin
                case (opcode)
                    OP_R:          nxt = R_EX;
                    OP_LW, OP_SW:  nxt = MEM_ADDR;
                    OP_BEQ:        nxt = BEQ;
                    OP_J:          nxt = JMP;
                    OP_ADDI:       nxt = I_EX;
                    default: begin nxt = FETCH; bad_op = 1'b1; end
                endcase
            end
            MEM_ADDR: nxt = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) nxt = MEM_WB;
            MEM_WR:   if (mem_ready) begin nxt = FETCH; retire = 1'b1; end
            R_EX:     nxt = R_WB;
            I_EX:     nxt = I_WB;
            MEM_WB, R_WB, I_WB, BEQ, JMP: begin nxt = FETCH; retire = 1'b1; end
            default:  nxt = FETCH;
        endcase
    end

    // Outputs are registered from the next state so they line up with cur.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= FETCH;
            ctl         <= dec(FETCH);
            instr_count <= '0;
            illegal     <= 1'b0;
        end else begin
            cur     <= nxt;
            ctl     <= dec(nxt);
            illegal <= bad_op;
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign state       = cur;
    assign PCWrite     = ctl.pcw | (ctl.fetch & mem_ready);
    assign IRWrite     = ctl.fetch & mem_ready;
    assign PCWriteCond = ctl.pcwc;
    assign IorD        = ctl.iord;
    assign MemRead     = ctl.mrd;
    assign MemWrite    = ctl.mwr;
    assign MemtoReg    = ctl.m2r;
    assign RegDst      = ctl.rdst;
    assign RegWrite    = ctl.rw;
    assign ALUIn1Sel   = ctl.in1;
    assign ALUIn2Sel   = ctl.in2;
    assign ALUOp       = ctl.aluop;
    assign PCSrc       = ctl.pcsrc;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instructions are expanded into expected per-cycle
// state/control traces and compared against the DUT every cycle.
module tb_multicycle_ctrl;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst, zero, mem_ready;
    logic [5:0] opcode;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUIn1Sel, illegal;
    logic [1:0] ALUIn2Sel, ALUOp, PCSrc;
    logic [3:0] state;
    logic [3:0] instr_count;

    multicycle_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUIn1Sel(ALUIn1Sel), .ALUIn2Sel(ALUIn2Sel), .ALUOp(ALUOp),
        .PCSrc(PCSrc), .state(state), .instr_count(instr_count), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         model_cnt;
    bit         pend_ill;
    int         dut_len;
    bit         left_fetch;
    logic [5:0] cur_op;

    typedef struct {
        logic [5:0] op;
        int         wf;
        int         wm;
        int         ncyc;
    } vec_t;
    vec_t tv[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Control table straight from the state descriptions; mr only matters in FETCH.
    function automatic logic [15:0] eo(input int s, input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, in1;
        logic [1:0] in2, op, src;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, in1} = '0;
        in2 = 2'b00; op = 2'b00; src = 2'b00;
        case (s)
            0:  begin mrd = 1; in2 = 2'b01; irw = mr; pcw = mr; end
            1:  in2 = 2'b10;
            2:  begin in1 = 1; in2 = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin in1 = 1; op = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin in1 = 1; op = 2'b01; pcwc = 1; src = 2'b01; end
            9:  begin pcw = 1; src = 2'b10; end
            10: begin in1 = 1; in2 = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, in1, in2, op, src};
    endfunction

    function automatic int cls(input logic [5:0] op);
        case (op)
            OP_R:    return 0;
            OP_LW:   return 1;
            OP_SW:   return 2;
            OP_BEQ:  return 3;
            OP_J:    return 4;
            OP_ADDI: return 5;
            default: return 6;
        endcase
    endfunction

    // One expected cycle: drive inputs at negedge, compare just after.
    task automatic cyc(input int s, input logic mr);
        @(negedge clk);
        mem_ready = mr;
        opcode    = cur_op;
        zero      = 1'($urandom);
        #1;
        chk("state", 32'(state), 32'(s));
        chk("ctrl", 32'({PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                         RegDst, RegWrite, ALUIn1Sel, ALUIn2Sel, ALUOp, PCSrc}), 32'(eo(s, mr)));
        chk("illegal", 32'(illegal), 32'(pend_ill));
        chk("count", 32'(instr_count), 32'(model_cnt));
        pend_ill = 1'b0;
        if (state != 4'd0) left_fetch = 1'b1;
        if (!left_fetch || state != 4'd0) dut_len++;
    endtask

    // Expand one instruction (with wf FETCH stalls and wm memory stalls) into its trace.
    task automatic exec(input logic [5:0] op, input int wf, input int wm);
        cur_op = op; dut_len = 0; left_fetch = 1'b0;
        repeat (wf) cyc(0, 1'b0);
        cyc(0, 1'b1);
        cyc(1, 1'($urandom));
        case (cls(op))
            0: begin cyc(6, 1'($urandom)); cyc(7, 1'($urandom)); end
            1: begin
                cyc(2, 1'($urandom));
                repeat (wm) cyc(3, 1'b0);
                cyc(3, 1'b1);
                cyc(4, 1'($urandom));
            end
            2: begin
                cyc(2, 1'($urandom));
                repeat (wm) cyc(5, 1'b0);
                cyc(5, 1'b1);
            end
            3: cyc(8, 1'($urandom));
            4: cyc(9, 1'($urandom));
            5: begin cyc(10, 1'($urandom)); cyc(11, 1'($urandom)); end
            default: pend_ill = 1'b1;
        endcase
        if (cls(op) != 6) model_cnt = (model_cnt + 1) % 16;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1; opcode = OP_R;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_memread", 32'(MemRead), 32'd1);
        chk("rst_alu2sel", 32'(ALUIn2Sel), 32'd1);
        chk("rst_pcwrite", 32'(PCWrite), 32'd1);
        chk("rst_illegal", 32'(illegal), 32'd0);
        rst = 1'b0; mem_ready = 1'b0;
        model_cnt = 0; pend_ill = 1'b0;
    endtask

    task automatic peek_count(input string nm, input int exp);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk(nm, 32'(instr_count), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = '0; cur_op = '0;
        model_cnt = 0; pend_ill = 1'b0;

        tv[0] = '{OP_R,    0, 0, 4};
        tv[1] = '{OP_LW,   0, 2, 7};
        tv[2] = '{OP_SW,   0, 0, 4};
        tv[3] = '{OP_BEQ,  0, 0, 3};
        tv[4] = '{OP_J,    0, 0, 3};
        tv[5] = '{OP_ADDI, 0, 0, 4};
        tv[6] = '{OP_BAD,  0, 0, 2};
        tv[7] = '{OP_LW,   1, 1, 7};
        tv[8] = '{OP_SW,   2, 3, 9};
        tv[9] = '{OP_R,    3, 0, 7};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            exec(tv[i].op, tv[i].wf, tv[i].wm);
            chk($sformatf("cycles[%0d]", i), 32'(dut_len), 32'(tv[i].ncyc));
        end

        // Reset while a store is stalled in MEM_WR: write dropped, count cleared.
        cur_op = OP_SW;
        cyc(0, 1'b1); cyc(1, 1'b1); cyc(2, 1'b1); cyc(5, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        chk("wr_rst_state", 32'(state), 32'd0);
        chk("wr_rst_memwrite", 32'(MemWrite), 32'd0);
        chk("wr_rst_count", 32'(instr_count), 32'd0);
        model_cnt = 0; pend_ill = 1'b0;

        // Randomized instruction stream with random stalls.
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op;
            case ($urandom_range(0, 7))
                0: op = OP_R;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_J;
                5: op = OP_ADDI;
                6: op = 6'($urandom);
                default: op = OP_BAD;
            endcase
            exec(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Counter wrap at 2^CNT_W.
        do_reset();
        repeat (15) exec(OP_J, 0, 0);
        peek_count("count_15", 15);
        exec(OP_J, 0, 0);
        peek_count("count_wrap", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
